// File: rtl/credit_pkg.sv
// Shared definitions for the credit manager slice.
//  - state_e : accounting FSM encodings (S_INIT, S_RUN, S_HOLD)
//  - Def*    : default price, credit ceiling and start-button holdoff
//  - BinW/BcdW : widths of the binary-to-BCD converter interface
package credit_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,  // baseline capture of the bill counter after reset
        S_RUN  = 2'd1,  // accounting, start edges accepted
        S_HOLD = 2'd2   // accounting, start edges ignored until holdoff expires
    } state_e;

    localparam int unsigned DefPrice        = 50;
    localparam int unsigned DefMaxCredit    = 4000;
    localparam int unsigned DefHoldoffTicks = 100000;  // 10 ms at 10 MHz

    localparam int unsigned BinW = 14;
    localparam int unsigned BcdW = 16;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to 4-digit BCD converter.
// A start while idle loads the W low bits of bin_i; W shift cycles follow, then done_o pulses for
// one cycle with bcd_o holding the result (bcd_o stays stable until the next start).
// Ports:
//  clk_i   in   1    clock
//  rst_i   in   1    asynchronous reset, active-high
//  start_i in   1    begin a conversion (ignored while busy)
//  bin_i   in   14   binary value, only the W low bits are converted
//  busy_o  out  1    conversion in progress
//  done_o  out  1    1-cycle pulse: bcd_o is valid
//  bcd_o   out  16   four BCD digits
module bin2bcd_seq
    import credit_pkg::*;
#(
    parameter int unsigned W = 14  // number of significant input bits, <= 14
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [BinW-1:0] bin_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [BcdW-1:0] bcd_o
);

    localparam int unsigned CntW = $clog2(W + 1);

    logic [BinW-1:0] shift_q, shift_d;
    logic [BcdW-1:0] bcd_q, bcd_d;
    logic [BcdW-1:0] adj;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        // Add-3 correction on every digit that would overflow past 9 after the shift.
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end

        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (busy_q) begin
            bcd_d    = adj << 1;
            bcd_d[0] = shift_q[BinW-1];
            shift_d  = shift_q << 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            // Left-align the significant bits so the MSB is always shifted out first.
            shift_d = bin_i << (BinW - W);
            bcd_d   = '0;
            cnt_d   = CntW'(W);
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/credit_manager.sv
// Credit manager: turns the bill validator's wrapping 8-bit running total into ruble credit and
// sells games against it on a start-button request.
// Optional feature macro: CREDIT_BCD_EN (adds a sequential BCD rendering of creditSum).
// Ports:
//  CLK_10MHZ    in   1         system clock
//  RST          in   1         asynchronous reset, active-high
//  billAccumed  in   8         bill validator running total, wraps mod 256
//  startReq     in   1         start button (synchronous), acts on rising edge
//  creditSum    out  CREDIT_W  current balance in rubles
//  gameStart    out  1         1-cycle pulse: game purchased
//  gameDenied   out  1         1-cycle pulse: start request with insufficient credit
//  ovfErr       out  1         sticky: a credit add was clipped at MAX_CREDIT
//  creditBcd    out  16        BCD of creditSum (constant 0 without CREDIT_BCD_EN)
//  bcdValid     out  1         creditBcd matches creditSum (constant 0 without CREDIT_BCD_EN)
module credit_manager
    import credit_pkg::*;
#(
    parameter int unsigned CREDIT_W      = 12,
    parameter int unsigned PRICE         = DefPrice,
    parameter int unsigned MAX_CREDIT    = DefMaxCredit,
    parameter int unsigned HOLDOFF_TICKS = DefHoldoffTicks
) (
    input  logic                CLK_10MHZ,
    input  logic                RST,
    input  logic [7:0]          billAccumed,
    input  logic                startReq,
    output logic [CREDIT_W-1:0] creditSum,
    output logic                gameStart,
    output logic                gameDenied,
    output logic                ovfErr,
    output logic [BcdW-1:0]     creditBcd,
    output logic                bcdValid
);

    localparam int unsigned SumW  = CREDIT_W + 1;
    localparam int unsigned HoldW = $clog2(HOLDOFF_TICKS + 1);

    state_e              state_q, state_d;
    logic [7:0]          prev_acc_q, prev_acc_d;
    logic                start_r_q, start_r_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                ovf_q, ovf_d;
    logic                game_start_q, game_start_d;
    logic                game_denied_q, game_denied_d;
    logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;

    logic [7:0]          delta;
    logic [SumW-1:0]     sum_raw;
    logic [SumW-1:0]     sum_clip;
    logic                clip;
    logic                afford;
    logic                start_edge;
    logic [CREDIT_W-1:0] credit_after_buy;

    // Modulo-256 difference absorbs the wrap of the validator's counter.
    assign delta            = billAccumed - prev_acc_q;
    assign sum_raw          = {1'b0, credit_q} + SumW'(delta);
    assign clip             = sum_raw > SumW'(MAX_CREDIT);
    assign sum_clip         = clip ? SumW'(MAX_CREDIT) : sum_raw;
    assign afford           = sum_clip >= SumW'(PRICE);
    assign credit_after_buy = sum_clip[CREDIT_W-1:0] - CREDIT_W'(PRICE);
    assign start_edge       = startReq & ~start_r_q;

    always_comb begin
        state_d       = state_q;
        prev_acc_d    = billAccumed;
        start_r_d     = startReq;
        credit_d      = credit_q;
        ovf_d         = ovf_q;
        game_start_d  = 1'b0;
        game_denied_d = 1'b0;
        hold_cnt_d    = hold_cnt_q;

        // The validator is not reset with us, so the first sample only sets the baseline.
        if (state_q != S_INIT) begin
            credit_d = sum_clip[CREDIT_W-1:0];
            ovf_d    = ovf_q | clip;
        end

        unique case (state_q)
            S_INIT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (start_edge) begin
                    // A bill landing in the same cycle already counts toward this purchase.
                    if (afford) begin
                        credit_d     = credit_after_buy;
                        game_start_d = 1'b1;
                    end else begin
                        game_denied_d = 1'b1;
                    end
                    hold_cnt_d = HoldW'(HOLDOFF_TICKS - 1);
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK_10MHZ or posedge RST) begin
        if (RST) begin
            state_q       <= S_INIT;
            prev_acc_q    <= '0;
            start_r_q     <= 1'b0;
            credit_q      <= '0;
            ovf_q         <= 1'b0;
            game_start_q  <= 1'b0;
            game_denied_q <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            prev_acc_q    <= prev_acc_d;
            start_r_q     <= start_r_d;
            credit_q      <= credit_d;
            ovf_q         <= ovf_d;
            game_start_q  <= game_start_d;
            game_denied_q <= game_denied_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign creditSum  = credit_q;
    assign gameStart  = game_start_q;
    assign gameDenied = game_denied_q;
    assign ovfErr     = ovf_q;

`ifdef CREDIT_BCD_EN
    logic [CREDIT_W-1:0] last_conv_q, last_conv_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic                bcd_valid_q, bcd_valid_d;
    logic                conv_start;
    logic                conv_busy;
    logic                conv_done;
    logic [BcdW-1:0]     conv_bcd;

    // A change seen mid-conversion is caught by the next start once the converter idles.
    assign conv_start = ~conv_busy & (credit_q != last_conv_q);

    bin2bcd_seq #(
        .W (CREDIT_W)
    ) u_bin2bcd (
        .clk_i   (CLK_10MHZ),
        .rst_i   (RST),
        .start_i (conv_start),
        .bin_i   (BinW'(credit_q)),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        last_conv_d = last_conv_q;
        bcd_d       = bcd_q;
        bcd_valid_d = bcd_valid_q;
        if (conv_done) begin
            bcd_d       = conv_bcd;
            bcd_valid_d = 1'b1;
        end
        // A new start in the done cycle means the result is already stale.
        if (conv_start) begin
            last_conv_d = credit_q;
            bcd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_10MHZ or posedge RST) begin
        if (RST) begin
            last_conv_q <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            last_conv_q <= last_conv_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign creditBcd = bcd_q;
    assign bcdValid  = bcd_valid_q;
`else
    assign creditBcd = '0;
    assign bcdValid  = 1'b0;
`endif

endmodule
